warning_annunciator: RTL and testbench
======================================

# warning_annunciator

Registered annunciator stage that sits directly downstream of `car_safety_system`. It consumes that block's 16-bit LED status bus and produces board LEDs and a chime drive. Priority warnings become blink patterns. Chime requests become a timed, burst-limited, acknowledgeable chime sequence.

## Interface
- `TICK_CYCLES`, default 1_000_000: clock cycles per timebase tick (10 ms at 100 MHz).
- `BLINK_TICKS`, default 25: fast-blink half-period in ticks. Slow-blink half-period is 2×BLINK_TICKS.
- `CHIME_ON_TICKS`, default 20: chime-on duration per burst, in ticks.
- `CHIME_OFF_TICKS`, default 30: gap between bursts, in ticks.
- `CHIME_MAX_BURSTS`, default 6: number of bursts before auto-mute. Legal range 1..255.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `status_in` input 16: `car_safety_system` `led` bus.
  - [15] START_PERMIT
  - [14] CHIME request
  - [13] WARN_PRI2 (high priority)
  - [12] WARN_PRI1 (low priority)
  - [11:0] individual warnings
- `ack_in` input 1: driver silence request, sampled as a level every cycle.
- `led_out` output 16: annunciated LED bus.
- `chime_out` output 1: chime drive, high while bursting.

## Operation
- Input stage: `status_in` registers into `status_q` every cycle. All logic below uses `status_q` only.
- Blink timebase:
  - Free-running prescaler `blk_pre` counts 0..TICK_CYCLES-1. It emits a one-cycle `blk_tick` on wrap.
  - The tick counter toggles `fast_ph` every BLINK_TICKS ticks and `slow_ph` every 2×BLINK_TICKS ticks.
  - `fast_ph` and `slow_ph` reset to 1, so a warning is lit immediately.
- LED mapping, registered:
  - `led_out[15]` = `status_q[15]`.
  - `led_out[14]` = chime FSM in ON.
  - `led_out[13]` = `status_q[13]` & `fast_ph`.
  - `led_out[12]` = `status_q[12]` & `slow_ph`.
  - `led_out[11:0]` = `status_q[11:0]`.
- Chime trigger: `trig` = `status_q[14]` | `status_q[13]`. `hi` = `status_q[13]`.
- Chime prescaler `chm_pre` is separate from `blk_pre`. It is cleared on every entry to ON or OFF, so each phase is exactly N×TICK_CYCLES cycles.
- Chime FSM states: IDLE, ON, OFF, MUTED. Reset state is IDLE, with `burst_cnt`=0.
  - IDLE: on `trig`, go to ON with `burst_cnt`=1.
  - ON: after CHIME_ON_TICKS chime ticks, go to OFF.
  - OFF: after CHIME_OFF_TICKS ticks:
    - `!trig` → IDLE.
    - `burst_cnt`==CHIME_MAX_BURSTS → MUTED.
    - Otherwise → ON with `burst_cnt`+1.
  - ON/OFF, any cycle: `!trig` → IDLE (abort, `chime_out` drops next edge). `ack_in` & `!hi` → MUTED.
  - High-priority rule: while `hi`=1, `ack_in` is ignored.
  - MUTED:
    - `!trig` → IDLE.
    - A rising edge of `hi` (`status_q[13]` 0→1) → ON with `burst_cnt`=1. A new high-priority fault re-arms the chime.
  - Priority when events coincide in one cycle: `!trig` > `ack_in` > timer expiry.
- `chime_out` is registered and equals (next state == ON).

## Timing
- Reset values: `led_out`=16'h0000, `chime_out`=0, `status_q`=0, FSM=IDLE, all counters 0, `fast_ph`=`slow_ph`=1.
- Reset asserted mid-burst: outputs go to reset values at that edge, regardless of state.
- Latency:
  - `status_in` → `led_out` steady bits: 2 edges.
  - `status_in[14]` rise from IDLE → `chime_out` high: 2 edges.
  - `ack_in` → `chime_out` low: 1 edge.
- Burst period is (CHIME_ON_TICKS + CHIME_OFF_TICKS)×TICK_CYCLES cycles.
- ON is exactly CHIME_ON_TICKS×TICK_CYCLES cycles with `chime_out`=1.
- Prescaler and tick counters wrap to 0 with no hold. Counter widths are $clog2 of their limits. `burst_cnt` is 8 bits.
- `ack_in` held high continuously in MUTED has no effect.

## Test plan
Bench parameters: TICK_CYCLES=4, BLINK_TICKS=2, CHIME_ON_TICKS=3, CHIME_OFF_TICKS=2, CHIME_MAX_BURSTS=2.
- Reset: hold `rst` 3 cycles with `status_in`=16'hFFFF → `led_out`=0 and `chime_out`=0 throughout. Two edges after release, `led_out[15]`=1.
- Chime bursts: `status_in`=16'h4000 held. Sequence from 2 edges after apply:
  - `chime_out`=1 for 12 cycles, 0 for 8, 1 for 12, 0 for 8.
  - Then MUTED: 0 indefinitely.
  - Drop `status_in[14]` → IDLE. Re-raise → new bursts.
- Ack: `status_in`=16'h4000. Pulse `ack_in` 1 cycle at cycle 5 of the first ON → `chime_out`=0 next edge, stays 0 while the request persists.
- High priority: `status_in`=16'h2000.
  - `ack_in` held high → bursts continue unaffected.
  - `led_out[13]` toggles every 8 cycles, first 8 cycles high.
- Re-arm: request 16'h4000 and mute via ack. Then set `status_in`=16'h6000 → `chime_out` high 2 edges later, `burst_cnt` restarts at 1.
- Slow blink plus abort: `status_in`=16'h1000 → `led_out[12]` toggles every 16 cycles. Separately, set 16'h4000, then clear it at cycle 4 of ON → `chime_out`=0 one edge after `status_q[14]` falls.

Source files
------------

// File: rtl/warning_annunciator.sv
// warning_annunciator: registers the car_safety_system LED bus, turns the two
// priority warnings into fast/slow blink and drives a timed, burst-limited,
// acknowledgeable chime.
module warning_annunciator #(
  parameter int TICK_CYCLES      = 1_000_000,
  parameter int BLINK_TICKS      = 25,
  parameter int CHIME_ON_TICKS   = 20,
  parameter int CHIME_OFF_TICKS  = 30,
  parameter int CHIME_MAX_BURSTS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] status_in,
  input  logic        ack_in,
  output logic [15:0] led_out,
  output logic        chime_out
);

  localparam int CHM_MAX = (CHIME_ON_TICKS > CHIME_OFF_TICKS) ? CHIME_ON_TICKS : CHIME_OFF_TICKS;
  localparam int PRE_W   = (TICK_CYCLES > 1)     ? $clog2(TICK_CYCLES)     : 1;
  localparam int BLK_W   = (2 * BLINK_TICKS > 1) ? $clog2(2 * BLINK_TICKS) : 1;
  localparam int CHM_W   = (CHM_MAX > 1)         ? $clog2(CHM_MAX)         : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_HALF  = BLK_W'(BLINK_TICKS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(2 * BLINK_TICKS - 1);
  localparam logic [CHM_W-1:0] ON_LAST   = CHM_W'(CHIME_ON_TICKS - 1);
  localparam logic [CHM_W-1:0] OFF_LAST  = CHM_W'(CHIME_OFF_TICKS - 1);
  localparam logic [7:0]       MAX_BURST = 8'(CHIME_MAX_BURSTS);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_MUTED} state_t;

  logic [15:0]      r_status_q;
  logic             r_hi_d;
  logic [PRE_W-1:0] r_blk_pre;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_fast_ph;
  logic             r_slow_ph;
  logic [PRE_W-1:0] r_chm_pre;
  logic [CHM_W-1:0] r_chm_cnt;
  logic [7:0]       r_burst_cnt;
  state_t           r_state;
  logic [15:0]      r_led;
  logic             r_chime;

  logic             w_blk_tick;
  logic             w_chm_tick;
  logic             w_trig;
  logic             w_hi;
  logic             w_hi_rise;
  logic             w_on_done;
  logic             w_off_done;
  state_t           w_next;
  logic [7:0]       w_burst_nxt;

  assign w_blk_tick = (r_blk_pre == PRE_LAST);
  assign w_chm_tick = (r_chm_pre == PRE_LAST);
  assign w_trig     = r_status_q[14] | r_status_q[13];
  assign w_hi       = r_status_q[13];
  assign w_hi_rise  = r_status_q[13] & ~r_hi_d;
  assign w_on_done  = w_chm_tick && (r_chm_cnt == ON_LAST);
  assign w_off_done = w_chm_tick && (r_chm_cnt == OFF_LAST);

  assign led_out   = r_led;
  assign chime_out = r_chime;

  // Input stage plus previous high-priority bit for rising-edge re-arm
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status_q <= '0;
      r_hi_d     <= 1'b0;
    end else begin
      r_status_q <= status_in;
      r_hi_d     <= r_status_q[13];
    end
  end

  // Free-running blink timebase; phases start at 1 so warnings light at once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_pre <= '0;
      r_blk_cnt <= '0;
      r_fast_ph <= 1'b1;
      r_slow_ph <= 1'b1;
    end else begin
      r_blk_pre <= w_blk_tick ? '0 : r_blk_pre + PRE_W'(1);
      if (w_blk_tick) begin
        if (r_blk_cnt == BLK_LAST) begin
          r_blk_cnt <= '0;
          r_fast_ph <= ~r_fast_ph;
          r_slow_ph <= ~r_slow_ph;
        end else begin
          r_blk_cnt <= r_blk_cnt + BLK_W'(1);
          if (r_blk_cnt == BLK_HALF) r_fast_ph <= ~r_fast_ph;
        end
      end
    end
  end

  // Chime next state; abort beats ack, ack beats timer expiry
  always_comb begin
    w_next      = r_state;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_next      = S_ON;
          w_burst_nxt = 8'd1;
        end
      end
      S_ON: begin
        if (!w_trig)                w_next = S_IDLE;
        else if (ack_in && !w_hi)   w_next = S_MUTED;
        else if (w_on_done)         w_next = S_OFF;
      end
      S_OFF: begin
        if (!w_trig)                w_next = S_IDLE;
        else if (ack_in && !w_hi)   w_next = S_MUTED;
        else if (w_off_done) begin
          if (r_burst_cnt == MAX_BURST) begin
            w_next = S_MUTED;
          end else begin
            w_next      = S_ON;
            w_burst_nxt = r_burst_cnt + 8'd1;
          end
        end
      end
      S_MUTED: begin
        if (!w_trig) begin
          w_next = S_IDLE;
        end else if (w_hi_rise) begin
          w_next      = S_ON;
          w_burst_nxt = 8'd1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Chime state and phase timer; timer restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_chm_pre   <= '0;
      r_chm_cnt   <= '0;
    end else begin
      r_state     <= w_next;
      r_burst_cnt <= w_burst_nxt;
      if (w_next != r_state) begin
        r_chm_pre <= '0;
        r_chm_cnt <= '0;
      end else if (r_state == S_ON || r_state == S_OFF) begin
        r_chm_pre <= w_chm_tick ? '0 : r_chm_pre + PRE_W'(1);
        if (w_chm_tick) r_chm_cnt <= r_chm_cnt + CHM_W'(1);
      end
    end
  end

  // Registered LED bus and chime drive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led   <= '0;
      r_chime <= 1'b0;
    end else begin
      r_led   <= {r_status_q[15], (w_next == S_ON),
                  r_status_q[13] & r_fast_ph, r_status_q[12] & r_slow_ph,
                  r_status_q[11:0]};
      r_chime <= (w_next == S_ON);
    end
  end

endmodule

// File: tb/tb_warning_annunciator.sv
// Bench for warning_annunciator: vector table, hand sequences for the chime
// corner cases, and a randomized run checked against a cycle-count model.
module tb_warning_annunciator;
  localparam int T = 4, B = 2, ON = 3, OFF = 2, MAXB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] status_in = '0;
  logic        ack_in = 1'b0;
  logic [15:0] led_out;
  logic        chime_out;

  warning_annunciator #(
    .TICK_CYCLES(T), .BLINK_TICKS(B), .CHIME_ON_TICKS(ON),
    .CHIME_OFF_TICKS(OFF), .CHIME_MAX_BURSTS(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .status_in(status_in), .ack_in(ack_in),
    .led_out(led_out), .chime_out(chime_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phases measured in elapsed cycles, blink from edges since reset
  typedef enum {M_IDLE, M_ON, M_OFF, M_MUTED} mst_t;
  mst_t        m_state;
  int          m_el, m_burst, m_k;
  logic [15:0] m_sq, m_led;
  logic        m_hi_prev, m_chime;

  typedef struct {
    logic [15:0] status;
    logic        ack;
    logic [15:0] exp_led;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic trig, hi, rise, fast, slow;
    mst_t nx;
    int   dur;
    if (rst) begin
      m_sq = '0; m_hi_prev = 1'b0; m_state = M_IDLE; m_el = 0; m_burst = 0;
      m_k = 0; m_led = '0; m_chime = 1'b0;
      return;
    end
    trig = m_sq[14] | m_sq[13];
    hi   = m_sq[13];
    rise = hi && !m_hi_prev;
    nx   = m_state;
    dur  = (m_state == M_ON) ? ON * T : OFF * T;
    case (m_state)
      M_IDLE: if (trig) begin nx = M_ON; m_burst = 1; end
      M_ON, M_OFF: begin
        if (!trig) nx = M_IDLE;
        else if (ack_in && !hi) nx = M_MUTED;
        else if (m_el + 1 == dur) begin
          if (m_state == M_ON) nx = M_OFF;
          else if (m_burst == MAXB) nx = M_MUTED;
          else begin nx = M_ON; m_burst++; end
        end
      end
      M_MUTED: begin
        if (!trig) nx = M_IDLE;
        else if (rise) begin nx = M_ON; m_burst = 1; end
      end
    endcase
    m_el    = (nx != m_state) ? 0 : m_el + 1;
    fast    = ((m_k / (T * B)) % 2) == 0;
    slow    = ((m_k / (2 * T * B)) % 2) == 0;
    m_led   = {m_sq[15], (nx == M_ON), m_sq[13] & fast, m_sq[12] & slow, m_sq[11:0]};
    m_chime = (nx == M_ON);
    m_state = nx;
    m_k++;
    m_hi_prev = m_sq[13];
    m_sq      = status_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_led", led_out, m_led);
    check("model_chime", {15'b0, chime_out}, {15'b0, m_chime});
  endtask

  task automatic do_reset(input logic [15:0] s);
    rst = 1'b1; status_in = s; ack_in = 1'b0;
    repeat (3) begin
      step();
      check("rst_led", led_out, 16'h0000);
      check("rst_chime", {15'b0, chime_out}, 16'h0000);
    end
    rst = 1'b0;
  endtask

  task automatic expect_chime(input string name, input int n, input logic v);
    repeat (n) begin
      step();
      check(name, {15'b0, chime_out}, {15'b0, v});
    end
  endtask

  vec_t vecs[7];
  logic [31:0] rnd;
  logic        exp_bit;

  initial begin
    vecs[0] = '{16'h8000, 1'b0, 16'h8000};
    vecs[1] = '{16'h0FFF, 1'b1, 16'h0FFF};
    vecs[2] = '{16'h8A5A, 1'b0, 16'h8A5A};
    vecs[3] = '{16'h0001, 1'b1, 16'h0001};
    vecs[4] = '{16'h0800, 1'b0, 16'h0800};
    vecs[5] = '{16'h0000, 1'b1, 16'h0000};
    vecs[6] = '{16'h8F0F, 1'b0, 16'h8F0F};

    // Reset with all inputs high, then START_PERMIT two edges after release
    do_reset(16'hFFFF);
    step();
    check("rel_led_edge1", led_out, 16'h0000);
    step();
    check("rel_led15", {15'b0, led_out[15]}, 16'h0001);

    // Steady LED mapping, two-edge latency, ack has no effect without a request
    do_reset(16'h0000);
    for (int i = 0; i < 7; i++) begin
      status_in = vecs[i].status;
      ack_in    = vecs[i].ack;
      step();
      step();
      check("vec_led", led_out, vecs[i].exp_led);
    end
    ack_in = 1'b0;

    // Burst sequence to auto-mute, then idle and re-request
    do_reset(16'h0000);
    status_in = 16'h4000;
    expect_chime("burst_lat", 1, 1'b0);
    expect_chime("burst_on1", 12, 1'b1);
    expect_chime("burst_off1", 8, 1'b0);
    expect_chime("burst_on2", 12, 1'b1);
    expect_chime("burst_off2", 8, 1'b0);
    expect_chime("burst_muted", 20, 1'b0);
    status_in = 16'h0000;
    expect_chime("burst_idle", 3, 1'b0);
    status_in = 16'h4000;
    expect_chime("burst_re_lat", 1, 1'b0);
    expect_chime("burst_re_on", 12, 1'b1);

    // Ack during the first ON silences on the next edge and stays silent
    do_reset(16'h0000);
    status_in = 16'h4000;
    expect_chime("ack_lat", 1, 1'b0);
    expect_chime("ack_on", 5, 1'b1);
    ack_in = 1'b1;
    expect_chime("ack_cut", 1, 1'b0);
    ack_in = 1'b0;
    expect_chime("ack_muted", 30, 1'b0);

    // High priority ignores a held ack; fast blink on led[13]
    do_reset(16'h0000);
    status_in = 16'h2000;
    ack_in    = 1'b1;
    step();
    check("hi_led13_e1", {15'b0, led_out[13]}, 16'h0000);
    for (int j = 2; j <= 41; j++) begin
      step();
      exp_bit = (j <= 13) || (j >= 22 && j <= 33);
      check("hi_chime", {15'b0, chime_out}, {15'b0, exp_bit});
      exp_bit = (((j - 1) / 8) % 2) == 0;
      check("hi_led13", {15'b0, led_out[13]}, {15'b0, exp_bit});
    end
    ack_in = 1'b0;

    // Mute in the second burst, then a new high-priority fault re-arms from burst 1
    do_reset(16'h0000);
    status_in = 16'h4000;
    expect_chime("rearm_lat0", 1, 1'b0);
    expect_chime("rearm_on_a", 12, 1'b1);
    expect_chime("rearm_off_a", 8, 1'b0);
    expect_chime("rearm_on_b", 2, 1'b1);
    ack_in = 1'b1;
    expect_chime("rearm_ack", 1, 1'b0);
    ack_in = 1'b0;
    expect_chime("rearm_quiet", 4, 1'b0);
    status_in = 16'h6000;
    expect_chime("rearm_lat", 1, 1'b0);
    expect_chime("rearm_on1", 12, 1'b1);
    expect_chime("rearm_off1", 8, 1'b0);
    expect_chime("rearm_on2", 12, 1'b1);
    expect_chime("rearm_off2", 8, 1'b0);
    expect_chime("rearm_mute", 10, 1'b0);

    // Slow blink on led[12]
    do_reset(16'h0000);
    status_in = 16'h1000;
    step();
    check("slow_led12_e1", {15'b0, led_out[12]}, 16'h0000);
    for (int j = 2; j <= 40; j++) begin
      step();
      exp_bit = (((j - 1) / 16) % 2) == 0;
      check("slow_led12", {15'b0, led_out[12]}, {15'b0, exp_bit});
    end

    // Request withdrawn at cycle 4 of ON aborts one edge after status_q falls
    do_reset(16'h0000);
    status_in = 16'h4000;
    expect_chime("abort_lat", 1, 1'b0);
    expect_chime("abort_on", 4, 1'b1);
    status_in = 16'h0000;
    expect_chime("abort_hold", 1, 1'b1);
    expect_chime("abort_drop", 1, 1'b0);
    expect_chime("abort_idle", 5, 1'b0);

    // Randomized run checked by the model every cycle
    do_reset(16'h0000);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 24) == 0) begin
        rnd = $urandom;
        status_in = rnd[15:0];
        if ($urandom_range(0, 1) == 0) status_in[13] = 1'b0;
      end
      ack_in = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
